// File: rtl/data_mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// data_mem_rr_arbiter : round-robin arbiter sharing one data-memory channel
//                       between NUM_CONSUMERS read/write requesters.
// Revision: 1.0
// ============================================================================
module data_mem_rr_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
  input  logic [ADDR_BITS-1:0]     consumer_read_address  [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
  output logic [DATA_BITS-1:0]     consumer_read_data     [NUM_CONSUMERS],
  input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
  input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
  input  logic [DATA_BITS-1:0]     consumer_write_data    [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
  output logic                     mem_read_valid,
  output logic [ADDR_BITS-1:0]     mem_read_address,
  input  logic                     mem_read_ready,
  input  logic [DATA_BITS-1:0]     mem_read_data,
  output logic                     mem_write_valid,
  output logic [ADDR_BITS-1:0]     mem_write_address,
  output logic [DATA_BITS-1:0]     mem_write_data,
  input  logic                     mem_write_ready,
  output logic                     busy
);

  localparam int                 c_PTR_W = $clog2(NUM_CONSUMERS);
  localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(NUM_CONSUMERS - 1);

  localparam logic [2:0] c_IDLE        = 3'd0;
  localparam logic [2:0] c_READ_WAIT   = 3'd1;
  localparam logic [2:0] c_WRITE_WAIT  = 3'd2;
  localparam logic [2:0] c_RELAY_READ  = 3'd3;
  localparam logic [2:0] c_RELAY_WRITE = 3'd4;

  logic [2:0]               r_state;
  logic [c_PTR_W-1:0]       r_ptr;
  logic [c_PTR_W-1:0]       r_grant;
  logic [NUM_CONSUMERS-1:0] w_req;
  logic                     w_found;
  logic [c_PTR_W-1:0]       w_cand;
  logic [c_PTR_W-1:0]       w_sel;
  logic [c_PTR_W-1:0]       w_sel_next;

  assign w_req = consumer_read_valid | consumer_write_valid;

  // Scan from the farthest slot back to r_ptr so the closest requester wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
      w_cand = c_PTR_W'((int'(r_ptr) + k) % NUM_CONSUMERS);
      if (w_req[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  // Explicit wrap since NUM_CONSUMERS need not be a power of two.
  assign w_sel_next = (w_sel == c_LAST) ? '0 : w_sel + c_PTR_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state              <= c_IDLE;
      r_ptr                <= '0;
      r_grant              <= '0;
      busy                 <= 1'b0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        consumer_read_data[i] <= '0;
      end
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_found) begin
            r_grant <= w_sel;
            r_ptr   <= w_sel_next;
            busy    <= 1'b1;
            // A consumer with both requests pending gets its read first.
            if (consumer_read_valid[w_sel]) begin
              mem_read_address <= consumer_read_address[w_sel];
              mem_read_valid   <= 1'b1;
              r_state          <= c_READ_WAIT;
            end else begin
              mem_write_address <= consumer_write_address[w_sel];
              mem_write_data    <= consumer_write_data[w_sel];
              mem_write_valid   <= 1'b1;
              r_state           <= c_WRITE_WAIT;
            end
          end
        end
        c_READ_WAIT: begin
          if (mem_read_ready) begin
            consumer_read_data[r_grant]  <= mem_read_data;
            consumer_read_ready[r_grant] <= 1'b1;
            mem_read_valid               <= 1'b0;
            r_state                      <= c_RELAY_READ;
          end
        end
        c_WRITE_WAIT: begin
          if (mem_write_ready) begin
            consumer_write_ready[r_grant] <= 1'b1;
            mem_write_valid               <= 1'b0;
            r_state                       <= c_RELAY_WRITE;
          end
        end
        c_RELAY_READ: begin
          if (!consumer_read_valid[r_grant]) begin
            consumer_read_ready[r_grant] <= 1'b0;
            busy                         <= 1'b0;
            r_state                      <= c_IDLE;
          end
        end
        c_RELAY_WRITE: begin
          if (!consumer_write_valid[r_grant]) begin
            consumer_write_ready[r_grant] <= 1'b0;
            busy                          <= 1'b0;
            r_state                       <= c_IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_data_mem_rr_arbiter : randomized transaction-level bench for the arbiter.
// Revision: 1.0
// ============================================================================
module tb_data_mem_rr_arbiter;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [N-1:0] rv = '0, wv = '0;
  logic [7:0] ra [N];
  logic [7:0] wa [N];
  logic [7:0] wd [N];
  logic [N-1:0] crr, cwr;
  logic [7:0] crd [N];
  logic       mrv, mwv, mrr = 1'b0, mwr = 1'b0, busy;
  logic [7:0] mra, mwa, mwd, mrd = '0;

  int total = 0;
  int bad   = 0;

  // Transaction-level model: pending requests per consumer and the rotating pointer.
  bit         m_rd [N];
  bit         m_wr [N];
  logic [7:0] m_ra [N];
  logic [7:0] m_wa [N];
  logic [7:0] m_wd [N];
  int         m_ptr;

  data_mem_rr_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(rv), .consumer_read_address(ra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(wv), .consumer_write_address(wa),
    .consumer_write_data(wd), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa), .mem_write_data(mwd),
    .mem_write_ready(mwr), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      m_rd[i] = 0; m_wr[i] = 0;
      rv[i] = 1'b0; wv[i] = 1'b0;
      ra[i] = '0; wa[i] = '0; wd[i] = '0;
    end
  endtask

  task automatic req_rd(input int i, input logic [7:0] a);
    m_rd[i] = 1; m_ra[i] = a; rv[i] = 1'b1; ra[i] = a;
  endtask

  task automatic req_wr(input int i, input logic [7:0] a, input logic [7:0] d);
    m_wr[i] = 1; m_wa[i] = a; m_wd[i] = d; wv[i] = 1'b1; wa[i] = a; wd[i] = d;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mrr = 1'b0; mwr = 1'b0;
    clear_reqs();
    m_ptr = 0;
    tick();
    tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  // Serve one transaction: predict the grant from the model, play memory, check the handshake.
  task automatic serve(input int delay, input bit drop_early, input bit scramble,
                       input logic [7:0] rdata, output int g, output bit is_rd);
    logic [7:0] ea, ed, a_now;
    logic [N-1:0] er;
    int hold;
    g = -1;
    is_rd = 0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (g < 0 && (m_rd[c] || m_wr[c])) g = c;
    end
    if (g < 0) begin
      total++; bad++;
      $display("FAIL serve_setup: got no pending request, required at least one");
      return;
    end
    is_rd = m_rd[g];
    ea = is_rd ? m_ra[g] : m_wa[g];
    ed = m_wd[g];
    m_ptr = (g + 1) % N;
    er = N'(1) << g;

    tick();
    total++;
    if (mrv !== is_rd || mwv !== !is_rd) begin
      bad++;
      $display("FAIL grant_type: got mrv=%0b mwv=%0b required read=%0b (consumer %0d)", mrv, mwv, is_rd, g);
    end
    a_now = is_rd ? mra : mwa;
    total++;
    if (a_now !== ea) begin
      bad++;
      $display("FAIL grant_addr: got %h required %h (consumer %0d)", a_now, ea, g);
    end
    if (!is_rd) begin
      total++;
      if (mwd !== ed) begin
        bad++;
        $display("FAIL grant_wdata: got %h required %h (consumer %0d)", mwd, ed, g);
      end
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL grant_busy: got %b required 1", busy);
    end

    if (drop_early) begin
      if (is_rd) rv[g] = 1'b0; else wv[g] = 1'b0;
    end
    if (scramble) begin
      if (is_rd) ra[g] = ~ea;
      else begin wa[g] = ~ea; wd[g] = ~ed; end
    end

    for (int d = 0; d < delay; d++) begin
      tick();
      a_now = is_rd ? mra : mwa;
      total++;
      if (mrv !== is_rd || mwv !== !is_rd || a_now !== ea || busy !== 1'b1 ||
          crr !== '0 || cwr !== '0) begin
        bad++;
        $display("FAIL wait_hold: cycle %0d got mrv=%0b mwv=%0b addr=%h busy=%b crr=%b cwr=%b required addr=%h",
                 d, mrv, mwv, a_now, busy, crr, cwr, ea);
      end
    end

    if (is_rd) begin mrr = 1'b1; mrd = rdata; end
    else mwr = 1'b1;
    tick();
    mrr = 1'b0; mwr = 1'b0; mrd = 8'($urandom);
    total++;
    if ((is_rd ? crr : cwr) !== er || (is_rd ? cwr : crr) !== '0 || mrv !== 1'b0 || mwv !== 1'b0) begin
      bad++;
      $display("FAIL complete_ready: got crr=%b cwr=%b mrv=%0b mwv=%0b required ready %b on read=%0b",
               crr, cwr, mrv, mwv, er, is_rd);
    end
    if (is_rd) begin
      total++;
      if (crd[g] !== rdata) begin
        bad++;
        $display("FAIL complete_rdata: got %h required %h (consumer %0d)", crd[g], rdata, g);
      end
    end

    if (!drop_early) begin
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
        mrr = 1'($urandom);
        mwr = 1'($urandom);
        tick();
        mrr = 1'b0; mwr = 1'b0;
        total++;
        if ((is_rd ? crr : cwr) !== er || mrv !== 1'b0 || mwv !== 1'b0 ||
            (is_rd && crd[g] !== rdata)) begin
          bad++;
          $display("FAIL relay_hold: got crr=%b cwr=%b mrv=%0b mwv=%0b data=%h required ready %b",
                   crr, cwr, mrv, mwv, crd[g], er);
        end
      end
      if (is_rd) rv[g] = 1'b0; else wv[g] = 1'b0;
    end
    if (is_rd) m_rd[g] = 0; else m_wr[g] = 0;

    tick();
    total++;
    if (crr !== '0 || cwr !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL release: got crr=%b cwr=%b busy=%b required all 0", crr, cwr, busy);
    end
    if (is_rd) begin
      total++;
      if (crd[g] !== rdata) begin
        bad++;
        $display("FAIL rdata_retained: got %h required %h", crd[g], rdata);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (busy !== 1'b0 || mrv !== 1'b0 || mwv !== 1'b0 || crr !== '0 || cwr !== '0 ||
        mra !== '0 || mwa !== '0 || mwd !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b mrv=%b mwv=%b crr=%b cwr=%b mra=%h mwa=%h mwd=%h required 0",
               busy, mrv, mwv, crr, cwr, mra, mwa, mwd);
    end
    for (int j = 0; j < N; j++) begin
      total++;
      if (crd[j] !== '0) begin
        bad++;
        $display("FAIL reset_rdata: consumer %0d got %h required 00", j, crd[j]);
      end
    end
  endtask

  task automatic test_single_read();
    int g; bit r;
    do_reset();
    req_rd(2, 8'h3C);
    serve(0, 0, 0, 8'hA5, g, r);
    total++;
    if (g !== 2 || r !== 1'b1) begin
      bad++;
      $display("FAIL single_read_grant: got consumer %0d read=%0b required 2 read=1", g, r);
    end
  endtask

  task automatic test_round_robin_writes();
    int g; bit r;
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) req_wr(i, 8'(i), 8'(8'h10 + i));
    for (int n = 0; n < 5; n++) begin
      serve(0, 0, 0, 8'h00, g, r);
      total++;
      if (g !== order[n] || r !== 1'b0) begin
        bad++;
        $display("FAIL rr_order: grant %0d got consumer %0d read=%0b required %0d write", n, g, r, order[n]);
      end
      if (g >= 0) req_wr(g, 8'(g), 8'(8'h10 + g));
    end
    clear_reqs();
  endtask

  task automatic test_read_write_same();
    int g; bit r;
    int  eg [4] = '{1, 2, 3, 1};
    bit  er [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    req_rd(1, 8'h05);
    req_wr(1, 8'h06, 8'h66);
    req_wr(2, 8'h20, 8'h22);
    req_rd(3, 8'h30);
    for (int n = 0; n < 4; n++) begin
      serve($urandom_range(0, 2), 0, 0, 8'($urandom), g, r);
      total++;
      if (g !== eg[n] || r !== er[n]) begin
        bad++;
        $display("FAIL rw_order: step %0d got consumer %0d read=%0b required %0d read=%0b", n, g, r, eg[n], er[n]);
      end
    end
  endtask

  task automatic test_stall();
    int g; bit r;
    do_reset();
    req_rd(0, 8'h44);
    serve(7, 0, 1, 8'h5A, g, r);
    total++;
    if (g !== 0 || r !== 1'b1) begin
      bad++;
      $display("FAIL stall_grant: got consumer %0d read=%0b required 0 read=1", g, r);
    end
  endtask

  task automatic test_drop_early();
    int g; bit r;
    do_reset();
    req_wr(3, 8'h77, 8'h99);
    serve(1, 1, 0, 8'h00, g, r);
    total++;
    if (g !== 3 || r !== 1'b0) begin
      bad++;
      $display("FAIL drop_grant: got consumer %0d read=%0b required 3 write", g, r);
    end
    mrr = 1'b1; mwr = 1'b1; mrd = 8'hEE;
    tick();
    mrr = 1'b0; mwr = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || mrv !== 1'b0 || mwv !== 1'b0 || crr !== '0 || cwr !== '0) begin
      bad++;
      $display("FAIL idle_ignore: got busy=%b mrv=%b mwv=%b crr=%b cwr=%b required 0", busy, mrv, mwv, crr, cwr);
    end
  endtask

  task automatic test_reset_mid();
    int g; bit r;
    do_reset();
    req_rd(2, 8'h12);
    tick();
    total++;
    if (mrv !== 1'b1) begin
      bad++;
      $display("FAIL midreset_setup: got mrv=%b required 1", mrv);
    end
    #3;
    reset = 1'b0;
    #1;
    total++;
    if (mrv !== 1'b0 || busy !== 1'b0 || crr !== '0 || cwr !== '0 || mra !== '0) begin
      bad++;
      $display("FAIL midreset_async: got mrv=%b busy=%b crr=%b cwr=%b mra=%h required 0", mrv, busy, crr, cwr, mra);
    end
    clear_reqs();
    m_ptr = 0;
    req_rd(3, 8'h33);
    req_wr(0, 8'h01, 8'h02);
    @(negedge clk);
    reset = 1'b1;
    serve(0, 0, 0, 8'h00, g, r);
    total++;
    if (g !== 0) begin
      bad++;
      $display("FAIL midreset_ptr: first grant got consumer %0d required 0", g);
    end
    serve(0, 0, 0, 8'hC3, g, r);
  endtask

  task automatic test_random();
    int g; bit r;
    bit any;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      any = 0;
      for (int i = 0; i < N; i++) begin
        if (!m_rd[i] && !m_wr[i]) begin
          case ($urandom_range(0, 3))
            1: req_rd(i, 8'($urandom));
            2: req_wr(i, 8'($urandom), 8'($urandom));
            3: begin req_rd(i, 8'($urandom)); req_wr(i, 8'($urandom), 8'($urandom)); end
            default: ;
          endcase
        end
        if (m_rd[i] || m_wr[i]) any = 1;
      end
      if (!any) req_wr($urandom_range(0, N - 1), 8'($urandom), 8'($urandom));
      serve($urandom_range(0, 3), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
            8'($urandom), g, r);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin ra[i] = '0; wa[i] = '0; wd[i] = '0; end
    test_reset();
    test_single_read();
    test_round_robin_writes();
    test_read_write_same();
    test_stall();
    test_drop_early();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
